// File: rtl/wallace_mul8_seq_if.sv
// Request/response bundle for the sequential 8x8 multiplier.
// in_valid/in_ready and out_valid/out_ready are valid/ready pairs: a transfer
// happens on a rising edge where both are high; valid must not depend on ready.
interface wallace_mul8_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        acc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;
    logic [1:0]  state;

    modport master (
        output in_valid, a, b, acc, out_ready,
        input  in_ready, out_valid, prod, state
    );

    modport slave (
        input  in_valid, a, b, acc, out_ready,
        output in_ready, out_valid, prod, state
    );
endinterface

// File: rtl/wallace_mul8_seq.sv
// Unsigned 8x8 multiply(-accumulate) built from one shared external 4x4
// wallace multiplier, stepping through the four nibble partial products.
module wallace_mul8_seq (
    input  logic                     clk,
    input  logic                     rst,
    wallace_mul8_seq_if.slave        bus,
    output logic [3:0]               mul_a,
    output logic [3:0]               mul_b,
    input  logic [7:0]               mul_prod
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  step;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [15:0] accum;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [15:0] addend;

    // step[0] selects the high nibble of a, step[1] the high nibble of b.
    always_comb begin
        mul_a  = 4'd0;
        mul_b  = 4'd0;
        addend = 16'd0;
        if (state == MUL) begin
            mul_a = step[0] ? op_a[7:4] : op_a[3:0];
            mul_b = step[1] ? op_b[7:4] : op_b[3:0];
            case (step)
                2'd0:       addend = {8'd0, mul_prod};
                2'd1, 2'd2: addend = {4'd0, mul_prod, 4'd0};
                default:    addend = {mul_prod, 8'd0};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step        <= 2'd0;
            op_a        <= 8'd0;
            op_b        <= 8'd0;
            accum       <= 16'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_a       <= bus.a;
                        op_b       <= bus.b;
                        if (!bus.acc) accum <= 16'd0;
                        step       <= 2'd0;
                        state      <= MUL;
                        in_ready_q <= 1'b0;
                    end
                end
                MUL: begin
                    accum <= accum + addend;
                    step  <= step + 2'd1;
                    if (step == 2'd3) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.prod      = accum;
    assign bus.state     = state;
endmodule

// File: tb/tb_wallace_mul8_seq.sv
// Directed bench for wallace_mul8_seq with a behavioural 4x4 multiplier
// standing in for the external wallace instance.
module tb_wallace_mul8_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_prod;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [7:0]  nib_log [4];
    logic [15:0] exp_q [$];

    wallace_mul8_seq_if bus ();

    wallace_mul8_seq dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_prod (mul_prod)
    );

    assign mul_prod = {4'd0, mul_a} * {4'd0, mul_b};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One full transaction; hold = cycles of out_ready low in DONE,
    // noise = keep in_valid high and scramble operands while busy.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic accv,
                          input logic [15:0] expv, input int hold, input bit noise);
        int n;
        exp_q.push_back(expv);
        @(negedge clk);
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.acc       = accv;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", (n < 20), 1);
        @(posedge clk);
        @(negedge clk);
        if (!noise) bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            if (n < 4) nib_log[n] = {mul_a, mul_b};
            if (noise) begin
                bus.a   = 8'($urandom_range(0, 255));
                bus.b   = 8'($urandom_range(0, 255));
                bus.acc = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        check("latency", n, 4);
        check("prod", bus.prod, exp_q.pop_front());
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_prod", bus.prod, expv);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_after", bus.state, 0);
        check("ready_after", bus.in_ready, 1);
        check("valid_after", bus.out_valid, 0);
    endtask

    initial begin
        int n;
        int acc_cyc [$];
        bit seen;
        bus.in_valid  = 1'b0;
        bus.a         = 8'd0;
        bus.b         = 8'd0;
        bus.acc       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_prod", bus.prod, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        rst = 1'b0;

        // Nibble order and latency
        run_op(8'hAB, 8'hCD, 1'b0, 16'h88EF, 0, 0);
        check("nib0", nib_log[0], 8'hBD);
        check("nib1", nib_log[1], 8'hAD);
        check("nib2", nib_log[2], 8'hBC);
        check("nib3", nib_log[3], 8'hAC);

        // Corners with back-pressure
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 10, 0);
        run_op(8'h00, 8'h9C, 1'b0, 16'h0000, 10, 0);

        // Accumulate with wrap
        run_op(8'd200, 8'd200, 1'b0, 16'd40000, 0, 0);
        run_op(8'd200, 8'd200, 1'b1, 16'd14464, 0, 0);
        run_op(8'd1, 8'd1, 1'b0, 16'd1, 0, 0);

        // Busy ignore: operands scrambled and in_valid held during MUL
        run_op(8'h5A, 8'h3C, 1'b0, 16'h1518, 0, 1);

        // Back-to-back throughput
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.a         = 8'd3;
        bus.b         = 8'd5;
        bus.acc       = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) acc_cyc.push_back(cyc);
            if (bus.out_valid) check("b2b_prod", bus.prod, 15);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("b2b_count", (acc_cyc.size() >= 3), 1);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 6);
        n = 0;
        while (bus.state != 2'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain", bus.state, 0);

        // Reset during MUL step 2
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.a         = 8'hAB;
        bus.b         = 8'hCD;
        bus.acc       = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("step2_mul_a", mul_a, 4'hB);
        check("step2_mul_b", mul_b, 4'hC);
        #1;
        rst = 1'b1;
        #1;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_prod", bus.prod, 0);
        check("abort_mul_a", mul_a, 0);
        check("abort_mul_b", mul_b, 0);
        check("abort_state", bus.state, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        run_op(8'h12, 8'h34, 1'b1, 16'h03A8, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wallace_mul8_seq.md
# wallace_mul8_seq

Sequencing controller that computes an unsigned 8x8 -> 16-bit product, with optional accumulate, using one shared 4x4 `wallace` multiplier instance. It splits the operands into nibbles, drives the four partial products through the multiplier one per cycle, and shift-accumulates the results. It sits between a valid/ready request source and the external combinational `wallace` instance, with `A`, `B` and `prod` wired to `mul_a`, `mul_b` and `mul_prod`.

## Interface
- No parameters. Widths are fixed by the 4x4 `wallace` datapath.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  controller can accept a request.
- `a`  in  8  multiplicand, unsigned.
- `b`  in  8  multiplier, unsigned.
- `acc`  in  1  1 = add product to previous result; 0 = start fresh. Sampled with `a`/`b`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `prod`  out  16  result register.
- `mul_a`  out  4  nibble to `wallace` input `A`.
- `mul_b`  out  4  nibble to `wallace` input `B`.
- `mul_prod`  in  8  `wallace` output `prod`, combinational from `mul_a`/`mul_b`.

## Operation
- States: IDLE, MUL, DONE. There is a 2-bit step counter `step` (0..3) that is meaningful only in MUL.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: latch `a`, `b` and `acc`.
  - If the latched `acc` = 0, clear the accumulator to 0. If it is 1, the accumulator keeps the last `prod`.
  - Set `step` = 0 and go to MUL.
- MUL:
  - `in_ready` = 0.
  - `mul_a` and `mul_b` are driven combinationally from the latched operands:
    - step 0: {a[3:0], b[3:0]}, shift 0.
    - step 1: {a[7:4], b[3:0]}, shift 4.
    - step 2: {a[3:0], b[7:4]}, shift 4.
    - step 3: {a[7:4], b[7:4]}, shift 8.
  - Each edge: accumulator += zero-extended `mul_prod` << shift. Addition is 16-bit, modulo 2^16.
  - After step 3, go to DONE.
- DONE:
  - `out_valid` = 1.
  - `prod` = accumulator, held stable until the handshake.
  - On `out_valid && out_ready`: go to IDLE.
- `mul_a` and `mul_b` are 0 in IDLE and DONE.
- `in_valid` outside IDLE is ignored, and the request is not consumed. `a`, `b` and `acc` changing during MUL have no effect.
- Accumulate mode:
  - The result equals (previous `prod` + a*b) mod 65536.
  - `acc` = 1 after reset adds to 0.
- `prod` is the accumulator register itself. It is visible in all states but is only guaranteed valid while `out_valid` = 1.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE, `step` = 0;
  - accumulator/`prod` = 16'h0000;
  - `in_ready` = 1, `out_valid` = 0;
  - `mul_a` = 0, `mul_b` = 0.
- Reset asserted mid-MUL or mid-DONE aborts the operation. No `out_valid` pulse is produced for the aborted request.
- Latency, with the accept edge as E0:
  - MUL steps 0..3 accumulate on E1..E4.
  - `out_valid` rises after E4, i.e. 4 cycles after accept.
- Handshake:
  - Earliest result handshake is E5; IDLE follows, and the earliest next accept is E6.
  - Maximum throughput is one product per 6 cycles.
  - `out_ready` held low stretches DONE indefinitely, with `prod` and `out_valid` stable.
- `out_ready` asserted before DONE has no effect.
- No combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`. Both are decoded from registered state only.
- `mul_prod` is sampled on the same edge where the step's nibbles were driven. This requires `wallace` to settle within one clock period.

## Test plan
- **Reset values:** assert `rst` -> `in_ready`=1, `out_valid`=0, `prod`=0, `mul_a`=`mul_b`=0.
- **Nibble sequence and 4-cycle latency:** accept a=0xAB, b=0xCD, acc=0.
  - `mul_a`/`mul_b` over E0..E3 = (B,D), (A,D), (B,C), (A,C).
  - `out_valid` high 4 cycles after accept, `prod`=0x88EF.
- **Corner values with back-pressure:**
  - a=0xFF, b=0xFF -> `prod`=0xFE01.
  - a=0x00, b=0x9C -> `prod`=0x0000.
  - For each, hold `out_ready`=0 for 10 cycles -> `prod` and `out_valid` stable throughout. `out_ready`=1 -> IDLE next cycle.
- **Accumulate with wrap:**
  - a=200, b=200, acc=0 -> `prod`=40000.
  - Then a=200, b=200, acc=1 -> `prod`=14464 (80000 mod 65536).
  - Then a=1, b=1, acc=0 -> `prod`=1.
- **Busy ignore and back-to-back:**
  - Hold `in_valid`=1 and change `a`/`b` during MUL -> result uses the originally accepted operands.
  - With `out_ready`=1 throughout, successive accepts are exactly 6 cycles apart.
- **Reset mid-operation:** assert `rst` during MUL step 2 -> all outputs at reset values and no `out_valid`. The next request 0x12 x 0x34 -> `prod`=0x03A8.
